dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipeline.
- Accepts read/write requests driven from the EX/MEM register outputs and services them after a fixed latency.
- Holds stall high so that PC, IF/ID, ID/EX and EX/MEM freeze until the response arrives.
- Completes each request with a one-cycle ready pulse, plus read data or an error flag.

Parameters:
- ADDR_W, 8, word-index width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 3, cycles from request acceptance to the ready cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- mem_read  in  1  read request; held stable by the stalled pipeline.
- mem_write  in  1  write request; held stable by the stalled pipeline.
- addr  in  32  byte address, from the EX/MEM alu_result.
- write_data  in  32  store data, from the EX/MEM forwarded rt value.
- read_data  out  32  load data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid with ready: misaligned address or illegal request.
- stall  out  1  freeze request to the pipeline, combinational.

Behaviour:
- Reset (rst=0 at a posedge):
  - state=IDLE, count=0.
  - read_data=0, ready=0, err=0; stall then depends only on inputs.
  - Memory array is not cleared.
  - Reset during BUSY or RESP aborts the request; a pending write is not committed.
- Request present: req = mem_read | mem_write.
- FSM states IDLE, BUSY, RESP:
  - IDLE: if req, latch op, addr and write_data, set count=LATENCY-1. Go to RESP if LATENCY=1, else BUSY.
  - BUSY: decrement count; when count reaches 1, go to RESP on the next edge.
  - RESP: ready=1 for exactly this cycle; next state is IDLE unconditionally.
- Timing: request first seen in cycle T gives ready in cycle T+LATENCY.
- stall = (state==IDLE & req) | (state==BUSY).
  - stall=0 in RESP, so the pipeline advances on the edge leaving RESP.
  - A back-to-back request is seen in IDLE on the very next cycle.
- Read: read_data = mem[latched addr[ADDR_W+1:2]] in RESP; 0 in every other cycle.
- Write: commits on the edge leaving RESP, only when err=0.
- Address handling: bits above ADDR_W+1 are ignored (aliasing wrap-around).
- err=1 in RESP when either condition holds; no write is performed and read_data=0:
  - latched addr[1:0] != 0 (misaligned), or
  - mem_read & mem_write were both 1 at acceptance.
- Inputs changing during BUSY are ignored; only the latched copy is used.
- Read-after-write to the same address in consecutive requests returns the new data, because the write has committed before the next RESP.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0], the count of cycles with stall=1.
  - Adds output req_count [31:0], the count of accepted requests.
  - Both counters are saturating and reset to 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - LATENCY_MIN=1 and LATENCY_MAX=15;
  - the count width (4).
- One sub-module, dmem_array:
  - 2**ADDR_W x 32 storage, synchronous write enable, asynchronous read.
  - Instantiated once; the FSM and latching stay in the top module.

Test Plan:
- Reset then read: rst=0 for 2 cycles, then mem_read=1, addr=0x10, LATENCY=3.
  - stall=1 for 3 cycles, ready=1 on the 4th cycle, read_data=0 from the preloaded array, err=0.
- Write then read: write 0xDEADBEEF to 0x20, then read 0x20 back-to-back.
  - First ready: err=0.
  - Second request accepted the cycle after the first ready.
  - Second ready: read_data=0xDEADBEEF.
- Misaligned access: mem_write=1, addr=0x22, write_data=0x1234.
  - ready with err=1; a later read of 0x20 still returns the prior value.
- Reset mid-operation: write to 0x40 accepted, rst=0 at cycle T+1.
  - ready never pulses, stall drops, a later read of 0x40 returns the old value.
- Illegal request and aliasing:
  - mem_read=mem_write=1 gives err=1 and no write.
  - With ADDR_W=8, addr=0x400 aliases 0x000 (read returns mem[0]).
- With LATENCY=1: stall high exactly 1 cycle per request; with DMEM_PERF_CNT_EN, stall_cycles=3 after 3 requests.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between pipeline and responder.
interface dmem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        err;
    logic        stall;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, ready, err, stall
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, ready, err, stall
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, single address.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder that stalls the pipeline per request.
// Define DMEM_PERF_CNT_EN to add stall_cycles/req_count counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    dmem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] req_count
`endif
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic        req;
    logic        resp;
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic        unused_addr;

    assign req         = bus.mem_read | bus.mem_write;
    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    addr_d  = bus.addr[ADDR_W+1:0];
                    wdata_d = bus.write_data;
                    count_d = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp = (state_q == RESP);
    assign err  = resp & ((addr_q[1:0] != 2'b00) | (rd_q & wr_q));
    // A reset landing on the RESP edge must not commit the write.
    assign we   = resp & wr_q & ~err & rst;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign bus.ready     = resp;
    assign bus.err       = err;
    assign bus.read_data = (resp & rd_q & ~err) ? rdata : 32'h0;
    assign bus.stall     = ((state_q == IDLE) & req) | (state_q == BUSY);

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] req_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            req_cnt_q   <= '0;
        end else begin
            if (bus.stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (state_q == IDLE && req && req_cnt_q != '1)
                req_cnt_q <= req_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign req_count    = req_cnt_q;
`endif

endmodule
